// File: rtl/adc_acondicionador.sv
// Two-channel ADC conditioner: synchroniser, offset removal, gain, saturation and offset auto-calibration.
// Optional DAC loopback onto channel B is enabled by defining ADC_ACOND_LOOPBACK_EN.
`timescale 1ns/1ps

module adc_acondicionador #(
    parameter int unsigned ADC_WIDTH      = 14,
    parameter int unsigned GAIN_WIDTH     = 8,
    parameter int unsigned SHIFT          = 6,
    parameter int unsigned OFFSET_DEFAULT = 6690,
    parameter int unsigned LOG2_NCAL      = 4
`ifdef ADC_ACOND_LOOPBACK_EN
    , parameter int unsigned LOOP_DELAY   = 30
`endif
) (
    input  logic                  clk125,
    input  logic                  sreset,
    input  logic [ADC_WIDTH-1:0]  adc_a_raw,
    input  logic [ADC_WIDTH-1:0]  adc_b_raw,
    input  logic [GAIN_WIDTH-1:0] gain_a,
    input  logic [GAIN_WIDTH-1:0] gain_b,
    input  logic                  cal_start,
    input  logic                  sat_clr,
`ifdef ADC_ACOND_LOOPBACK_EN
    input  logic [ADC_WIDTH-1:0]  dac_loop,
    input  logic                  loop_sel,
`endif
    output logic [ADC_WIDTH-1:0]  adc_a,
    output logic [ADC_WIDTH-1:0]  adc_b,
    output logic                  valid,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic                  sat_a,
    output logic                  sat_b,
    output logic [ADC_WIDTH-1:0]  offset_a,
    output logic [ADC_WIDTH-1:0]  offset_b
);

    localparam int unsigned CENT_W = ADC_WIDTH + 1;
    localparam int unsigned PROD_W = CENT_W + GAIN_WIDTH + 1;
    localparam int unsigned ACC_W  = ADC_WIDTH + LOG2_NCAL;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (ADC_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [ADC_WIDTH-1:0]     OFF_RST = ADC_WIDTH'(OFFSET_DEFAULT);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} cal_state_e;

    logic [ADC_WIDTH-1:0]     raw_c   [2];
    logic [GAIN_WIDTH-1:0]    gain_c  [2];
    logic [ADC_WIDTH-1:0]     sync1_q [2];
    logic [ADC_WIDTH-1:0]     sync2_q [2];
    logic signed [CENT_W-1:0] cent_q  [2];
    logic signed [CENT_W-1:0] cent_d  [2];
    logic signed [PROD_W-1:0] prod_q  [2];
    logic signed [PROD_W-1:0] prod_d  [2];
    logic signed [PROD_W-1:0] shr_c   [2];
    logic [ADC_WIDTH-1:0]     out_q   [2];
    logic [ADC_WIDTH-1:0]     out_d   [2];
    logic                     sat_q   [2];
    logic                     clip_c  [2];
    logic [2:0]               fill_q;
    logic                     valid_q;
    logic                     fill_c;

    cal_state_e               state_q, state_d;
    logic [ACC_W-1:0]         acc_q    [2];
    logic [ACC_W-1:0]         acc_d    [2];
    logic [ADC_WIDTH-1:0]     offset_q [2];
    logic [ADC_WIDTH-1:0]     offset_d [2];
    logic [LOG2_NCAL-1:0]     cnt_q, cnt_d;
    logic                     cal_busy_q, cal_busy_d;
    logic                     cal_done_q, cal_done_d;

`ifdef ADC_ACOND_LOOPBACK_EN
    logic [ADC_WIDTH-1:0]     dly_q [LOOP_DELAY];

    always_ff @(posedge clk125) begin
        if (sreset) begin
            for (int i = 0; i < int'(LOOP_DELAY); i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= dac_loop;
            for (int i = 1; i < int'(LOOP_DELAY); i++) dly_q[i] <= dly_q[i-1];
        end
    end
`endif

    always_comb begin
        raw_c[0]  = adc_a_raw;
        raw_c[1]  = adc_b_raw;
        gain_c[0] = gain_a;
        gain_c[1] = gain_b;
    end

    // Stage logic S3..S5: centre, scale, shift and clamp.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            cent_d[ch] = $signed({1'b0, sync2_q[ch]}) - $signed({1'b0, offset_q[ch]});
            prod_d[ch] = PROD_W'(cent_q[ch]) * PROD_W'($signed({1'b0, gain_c[ch]}));
            shr_c[ch]  = prod_q[ch] >>> SHIFT;
            clip_c[ch] = (shr_c[ch] > SAT_MAX) || (shr_c[ch] < SAT_MIN);
            if (shr_c[ch] > SAT_MAX)      out_d[ch] = ADC_WIDTH'(SAT_MAX);
            else if (shr_c[ch] < SAT_MIN) out_d[ch] = ADC_WIDTH'(SAT_MIN);
            else                          out_d[ch] = ADC_WIDTH'(shr_c[ch]);
        end
`ifdef ADC_ACOND_LOOPBACK_EN
        if (loop_sel) begin
            out_d[1]  = ADC_WIDTH'($signed(dly_q[LOOP_DELAY-1]) >>> 1);
            clip_c[1] = 1'b0;
        end
`endif
    end

    // S5 is held at zero until the first post-reset sample arrives, so fill garbage never reaches the flags.
    assign fill_c = valid_q | (fill_q == 3'd4);

    always_ff @(posedge clk125) begin
        if (sreset) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                sync1_q[ch] <= '0;
                sync2_q[ch] <= '0;
                cent_q[ch]  <= '0;
                prod_q[ch]  <= '0;
                out_q[ch]   <= '0;
                sat_q[ch]   <= 1'b0;
            end
        end else begin
            if (!valid_q) fill_q <= fill_q + 3'd1;
            if (fill_c)   valid_q <= 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                sync1_q[ch] <= raw_c[ch];
                sync2_q[ch] <= sync1_q[ch];
                cent_q[ch]  <= cent_d[ch];
                prod_q[ch]  <= prod_d[ch];
                if (fill_c) begin
                    out_q[ch] <= out_d[ch];
                    sat_q[ch] <= clip_c[ch] | (sat_q[ch] & ~sat_clr);
                end
            end
        end
    end

    always_ff @(posedge clk125) begin
        if (sreset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cal_busy_q <= 1'b0;
            cal_done_q <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                acc_q[ch]    <= '0;
                offset_q[ch] <= OFF_RST;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cal_busy_q <= cal_busy_d;
            cal_done_q <= cal_done_d;
            for (int ch = 0; ch < 2; ch++) begin
                acc_q[ch]    <= acc_d[ch];
                offset_q[ch] <= offset_d[ch];
            end
        end
    end

    // Calibration: average 2^LOG2_NCAL synchronised samples per channel, then swap in the new offsets.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cal_busy_d = cal_busy_q;
        cal_done_d = 1'b0;
        acc_d      = acc_q;
        offset_d   = offset_q;
        case (state_q)
            IDLE: begin
                if (cal_start) begin
                    state_d    = ACCUM;
                    cnt_d      = '0;
                    cal_busy_d = 1'b1;
                    for (int ch = 0; ch < 2; ch++) acc_d[ch] = '0;
                end
            end
            ACCUM: begin
                for (int ch = 0; ch < 2; ch++) acc_d[ch] = acc_q[ch] + ACC_W'(sync2_q[ch]);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {LOG2_NCAL{1'b1}}) state_d = UPDATE;
            end
            UPDATE: begin
                for (int ch = 0; ch < 2; ch++) offset_d[ch] = ADC_WIDTH'(acc_q[ch] >> LOG2_NCAL);
                cal_done_d = 1'b1;
                cal_busy_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc_a    = out_q[0];
    assign adc_b    = out_q[1];
    assign sat_a    = sat_q[0];
    assign sat_b    = sat_q[1];
    assign valid    = valid_q;
    assign cal_busy = cal_busy_q;
    assign cal_done = cal_done_q;
    assign offset_a = offset_q[0];
    assign offset_b = offset_q[1];

endmodule

// File: tb/tb_adc_acondicionador.sv
// Scoreboard bench for adc_acondicionador: per-edge expectations from a cycle-indexed arithmetic model.
`timescale 1ns/1ps

module tb_adc_acondicionador;

    localparam int MAXC = 2048;

    logic        clk125 = 1'b0;
    logic        sreset;
    logic [13:0] adc_a_raw, adc_b_raw;
    logic [7:0]  gain_a, gain_b;
    logic        cal_start, sat_clr;
    logic [13:0] adc_a, adc_b, offset_a, offset_b;
    logic        valid, cal_busy, cal_done, sat_a, sat_b;
`ifdef ADC_ACOND_LOOPBACK_EN
    logic [13:0] dac_loop;
    logic        loop_sel;
    int          lb_dac = 0;
    bit          lb_sel = 1'b0;
    int          dac_h  [MAXC];
    bit          lsel_h [MAXC];
`endif

    always #4 clk125 = ~clk125;

    adc_acondicionador dut (
        .clk125    (clk125),
        .sreset    (sreset),
        .adc_a_raw (adc_a_raw),
        .adc_b_raw (adc_b_raw),
        .gain_a    (gain_a),
        .gain_b    (gain_b),
        .cal_start (cal_start),
        .sat_clr   (sat_clr),
`ifdef ADC_ACOND_LOOPBACK_EN
        .dac_loop  (dac_loop),
        .loop_sel  (loop_sel),
`endif
        .adc_a     (adc_a),
        .adc_b     (adc_b),
        .valid     (valid),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .sat_a     (sat_a),
        .sat_b     (sat_b),
        .offset_a  (offset_a),
        .offset_b  (offset_b)
    );

    typedef struct {
        int n;
        int adc_a, adc_b, valid, sat_a, sat_b, busy, done, off_a, off_b;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Model state, indexed by edge number n (inputs driven before edge n).
    int  raw_h  [2][MAXC];
    int  gain_h [2][MAXC];
    int  offr_h [2][MAXC];
    int  n_edge    = 0;
    int  since_rst = 0;
    int  last_rst  = 0;
    int  cal_k     = 0;
    bit  cal_act   = 1'b0;
    int  off_m [2] = '{6690, 6690};
    bit  sat_m [2] = '{1'b0, 1'b0};
    int  out_m [2] = '{0, 0};

    function automatic void chk(input string nm, input int n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %0d expected %0d", nm, n, act, exp);
        end
    endfunction

    // Drive one cycle of inputs, predict the state after the coming edge, queue it.
    task automatic drive(input bit r, input int ra, input int rb, input int ga, input int gb,
                         input bit cs, input bit sc);
        exp_t e;
        int   n, c, p, q, sum;
        bit   clip, done, vld;
        sreset    = r;
        adc_a_raw = 14'(ra);
        adc_b_raw = 14'(rb);
        gain_a    = 8'(ga);
        gain_b    = 8'(gb);
        cal_start = cs;
        sat_clr   = sc;
        n_edge++;
        n = n_edge;
`ifdef ADC_ACOND_LOOPBACK_EN
        dac_loop  = 14'(lb_dac);
        loop_sel  = lb_sel;
        dac_h[n]  = lb_dac;
        lsel_h[n] = lb_sel;
`endif
        raw_h[0][n]  = r ? 0 : ra;
        raw_h[1][n]  = r ? 0 : rb;
        gain_h[0][n] = ga;
        gain_h[1][n] = gb;
        done = 1'b0;
        vld  = 1'b0;
        if (r) begin
            since_rst = 0;
            last_rst  = n;
            cal_act   = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                off_m[ch] = 6690;
                sat_m[ch] = 1'b0;
                out_m[ch] = 0;
            end
        end else begin
            since_rst++;
            if (cal_act && n == cal_k + 17) begin
                for (int ch = 0; ch < 2; ch++) begin
                    sum = 0;
                    for (int i = cal_k - 1; i <= cal_k + 14; i++) sum += raw_h[ch][i];
                    off_m[ch] = sum / 16;
                end
                done    = 1'b1;
                cal_act = 1'b0;
            end else if (!cal_act && cs) begin
                cal_act = 1'b1;
                cal_k   = n;
            end
            vld = (since_rst >= 5);
            if (vld) begin
                for (int ch = 0; ch < 2; ch++) begin
                    c    = raw_h[ch][n-4] - offr_h[ch][n-3];
                    p    = c * gain_h[ch][n-1];
                    q    = p >>> 6;
                    clip = (q > 8191) || (q < -8192);
                    out_m[ch] = clip ? ((q > 0) ? 8191 : -8192) : q;
`ifdef ADC_ACOND_LOOPBACK_EN
                    if (ch == 1 && lsel_h[n]) begin
                        out_m[1] = (n - 30 > last_rst) ? (dac_h[n-30] >>> 1) : 0;
                        clip     = 1'b0;
                    end
`endif
                    sat_m[ch] = clip || (sat_m[ch] && !sc);
                end
            end
        end
        offr_h[0][n] = off_m[0];
        offr_h[1][n] = off_m[1];
        e.n     = n;
        e.adc_a = out_m[0];
        e.adc_b = out_m[1];
        e.valid = int'(vld);
        e.sat_a = int'(sat_m[0]);
        e.sat_b = int'(sat_m[1]);
        e.busy  = int'(cal_act);
        e.done  = int'(done);
        e.off_a = off_m[0];
        e.off_b = off_m[1];
        sbq.push_back(e);
        @(negedge clk125);
    endtask

    // Monitor: one expectation per edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk125);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("adc_a",    e.n, int'($signed(adc_a)), e.adc_a);
                chk("adc_b",    e.n, int'($signed(adc_b)), e.adc_b);
                chk("valid",    e.n, int'(valid),          e.valid);
                chk("sat_a",    e.n, int'(sat_a),          e.sat_a);
                chk("sat_b",    e.n, int'(sat_b),          e.sat_b);
                chk("cal_busy", e.n, int'(cal_busy),       e.busy);
                chk("cal_done", e.n, int'(cal_done),       e.done);
                chk("offset_a", e.n, int'(offset_a),       e.off_a);
                chk("offset_b", e.n, int'(offset_b),       e.off_b);
            end
        end
    end

    initial begin
        int ga, gb, ra, rb;
        repeat (3)  drive(1, 6690, 6690, 174, 174, 0, 0);
        repeat (12) drive(0, 6690, 6690, 174, 174, 0, 0);
        repeat (8)  drive(0, 8000, 6690, 174, 174, 0, 0);
        repeat (6)  drive(0, 16383, 16383, 174, 174, 0, 0);
        repeat (6)  drive(0, 0, 0, 174, 174, 0, 0);
        repeat (6)  drive(0, 8000, 8000, 174, 174, 0, 0);
        drive(0, 8000, 8000, 174, 174, 0, 1);
        repeat (6)  drive(0, 8000, 8000, 174, 174, 0, 0);
        drive(0, 16383, 8000, 174, 174, 0, 0);
        repeat (3)  drive(0, 8000, 8000, 174, 174, 0, 0);
        drive(0, 8000, 8000, 174, 174, 0, 1);
        repeat (6)  drive(0, 8000, 8000, 174, 174, 0, 0);
        repeat (6)  drive(0, 16383, 0, 0, 0, 0, 0);
        drive(0, 16383, 0, 0, 0, 0, 1);
        repeat (6)  drive(0, 16383, 0, 0, 0, 0, 0);

        // Calibration with a second request while busy
        repeat (6)  drive(0, 7000, 6000, 174, 174, 0, 0);
        drive(0, 7000, 6000, 174, 174, 1, 0);
        repeat (4)  drive(0, 7000, 6000, 174, 174, 0, 0);
        drive(0, 7000, 6000, 174, 174, 1, 0);
        repeat (35) drive(0, 7000, 6000, 174, 174, 0, 0);

        // Randomised traffic with occasional gain changes, clears and calibrations
        ga = 174;
        gb = 174;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ga = int'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) gb = int'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : 6000 + int'($urandom_range(0, 2000));
            rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : 6000 + int'($urandom_range(0, 2000));
            drive(0, ra, rb, ga, gb, ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0));
        end
        repeat (20) drive(0, 7000, 6000, 174, 174, 0, 0);

        // Reset eight edges into a calibration
        drive(0, 7000, 6000, 174, 174, 1, 0);
        repeat (7)  drive(0, 7000, 6000, 174, 174, 0, 0);
        drive(1, 7000, 6000, 174, 174, 0, 0);
        repeat (25) drive(0, 7000, 6000, 174, 174, 0, 0);

`ifdef ADC_ACOND_LOOPBACK_EN
        lb_sel = 1'b1;
        lb_dac = 0;
        repeat (35) drive(0, 7000, 6000, 174, 174, 0, 0);
        lb_dac = 1000;
        repeat (40) drive(0, 7000, 6000, 174, 174, 0, 0);
        lb_dac = -3;
        repeat (40) drive(0, 7000, 6000, 174, 174, 0, 0);
        lb_sel = 1'b0;
        repeat (10) drive(0, 7000, 6000, 174, 174, 0, 0);
`endif

        repeat (3) @(posedge clk125);
        #2;
        chk("queue_drain", n_edge, sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_acondicionador.md
Name: adc_acondicionador

Overview:
- Two-channel conditioning front end between the high-speed ADC pins (ADC_DA/ADC_DB, 14-bit offset-binary) and the sweep control path that consumes signed 14-bit samples.
- Synchronises raw samples into the 125 MHz domain and removes the DC offset.
- Applies a per-channel gain and saturates the result to signed 14-bit.
- Includes a run-time offset auto-calibration FSM that replaces the fixed offset constant.

Parameters:
- ADC_WIDTH, 14: raw and output sample width.
- GAIN_WIDTH, 8: unsigned gain width.
- SHIFT, 6: arithmetic right shift applied after the multiply.
- OFFSET_DEFAULT, 6690: offset used after reset, before any calibration.
- LOG2_NCAL, 4: calibration averages 2^LOG2_NCAL samples per channel.
- LOOP_DELAY, 30: loopback delay depth in cycles (only used with the optional feature).

Ports:
- clk125  in  1  sole clock, 125 MHz.
- sreset  in  1  synchronous reset, active-high.
- adc_a_raw  in  14  channel A raw, offset-binary, asynchronous to clk125.
- adc_b_raw  in  14  channel B raw, offset-binary, asynchronous to clk125.
- gain_a  in  8  unsigned gain, channel A (0xAE nominal).
- gain_b  in  8  unsigned gain, channel B.
- cal_start  in  1  single-cycle pulse that requests offset calibration.
- sat_clr  in  1  clears the sticky saturation flags.
- adc_a  out  14  signed conditioned sample, channel A.
- adc_b  out  14  signed conditioned sample, channel B.
- valid  out  1  high once the pipeline is filled.
- cal_busy  out  1  high while calibration runs.
- cal_done  out  1  one-cycle pulse when new offsets are loaded.
- sat_a  out  1  sticky saturation flag, channel A.
- sat_b  out  1  sticky saturation flag, channel B.
- offset_a  out  14  current channel A offset.
- offset_b  out  14  current channel B offset.

Interface decision: one clock, clk125; reset is sreset, synchronous and active-high.

Behaviour:
- Reset values (sreset, sampled on a clk125 edge):
  - adc_a, adc_b, valid, cal_busy, cal_done, sat_a, sat_b = 0.
  - offset_a, offset_b = OFFSET_DEFAULT.
  - FSM = IDLE; all pipeline registers and accumulators cleared.
- Datapath pipeline, per channel, one stage per clk125 edge:
  - S1, S2: two-flop synchroniser.
  - S3: centered = {0,raw} - {0,offset}, 15-bit signed.
  - S4: prod = centered * {0,gain}, 24-bit signed.
  - S5: out = sat(prod >>> SHIFT) to [-8192, 8191], registered into adc_x.
- Latency: raw → adc_x is 5 cycles.
- valid: rises on the 5th edge after sreset deasserts and stays high until the next sreset.
- Saturation flags: sat_x sets on any cycle S5 clips. sat_clr clears both flags. If a clip and sat_clr occur in the same cycle, set wins.
- Calibration FSM states: IDLE, ACCUM, UPDATE.
  - IDLE: cal_start=1 at edge k → ACCUM from k+1; both accumulators cleared; cal_busy=1.
  - ACCUM: accumulators (ADC_WIDTH+LOG2_NCAL bits, unsigned) add the S2 synchronised raw samples on edges k+1 .. k+2^LOG2_NCAL. A counter tracks the count; at terminal count → UPDATE.
  - UPDATE: offset_x <= acc_x >> LOG2_NCAL (truncating); cal_done=1 for exactly one cycle; cal_busy=0; → IDLE.
- Offset handover: the datapath keeps using the old offset during ACCUM. The new offset applies to S3 from the cycle after UPDATE.
- cal_start while cal_busy=1 is ignored; no restart, no extension.
- sreset mid-calibration: abort to IDLE, offsets return to OFFSET_DEFAULT, no cal_done pulse.
- Gain inputs are sampled at S4 every cycle; no handshake. gain=0 → output 0 with no saturation.

Optional Feature:
- Macro: ADC_ACOND_LOOPBACK_EN.
- When defined:
  - Adds input dac_loop[13:0] (signed DAC sample) and input loop_sel.
  - dac_loop feeds a LOOP_DELAY-deep shift register, cleared by sreset.
  - With loop_sel=1, adc_b = {d[13], d[13:1]} (arithmetic halving) of the delayed sample. Latency dac_loop → adc_b is LOOP_DELAY+1 cycles.
  - In loopback mode sat_b is not updated.
- When undefined: neither port exists, no delay register, and channel B always uses the ADC path.

Test Plan:
- Offset zero point: reset, gain_a=0xAE, adc_a_raw=6690 constant → adc_a=0 from the 5th edge, valid rises on edge 5, sat_a=0.
- Nominal gain: raw=8000, gain=0xAE → 1310*174=227940, >>>6 → adc_a=3561 exactly 5 cycles after the input change.
- Positive clip: raw=16383 → adc_a=8191, sat_a=1. Negative clip: raw=0 → adc_a=-8192. sat_clr pulse with raw=8000 → sat_a=0. Clip coincident with sat_clr → sat_a stays 1.
- Calibration: raw A=7000, B=6000, cal_start pulse at edge k → cal_busy over k+1..k+17, cal_done pulse after edge k+17, offset_a=7000, offset_b=6000; adc_a=adc_b=0 after pipeline refill. A second cal_start during busy is ignored.
- Reset at edge k+8 of a calibration → offsets revert to 6690, no cal_done, FSM IDLE, valid=0.
- Loopback (ADC_ACOND_LOOPBACK_EN): loop_sel=1, dac_loop=1000 step → adc_b=500 exactly 31 cycles later, 0 before that. Negative input -3 → -2.
